// File: rtl/residual_decoder.sv
// residual_decoder
//   Reconstructs audio samples from a linear-prediction residual stream.
//   A frame starts with a coefficient load (order M, quantization shift and
//   M coefficients, one per iLoad cycle). Then M verbatim warm-up samples
//   are passed through and recorded. Every later residual is added to the
//   prediction  (sum c[k]*s[n-k]) >>> shift  to give the output sample.
//
// Parameters
//   MAX_ORDER  maximum predictor order
//   COEFF_W    signed coefficient width
//   SAMPLE_W   signed residual / sample width
//
// Ports
//   iClock     clock, all state on the rising edge
//   iReset     asynchronous active-low reset
//   iEnable    clock enable; low freezes everything and forces oValid=0
//   iLoad      coefficient-load strobe (starts or aborts a frame)
//   iM         predictor order, sampled on the first iLoad cycle
//   iShift     quantization shift, sampled on the first iLoad cycle
//   iCoeff     coefficient c[k], k = 1..M in load order
//   iResidual  residual, or a verbatim sample during warm-up
//   iValid     iResidual is valid this cycle
//   oSample    registered reconstructed sample
//   oValid     one-cycle pulse per output sample
module residual_decoder #(
  parameter int MAX_ORDER = 12,
  parameter int COEFF_W   = 12,
  parameter int SAMPLE_W  = 16
) (
  input  logic                       iClock,
  input  logic                       iReset,
  input  logic                       iEnable,
  input  logic                       iLoad,
  input  logic [3:0]                 iM,
  input  logic [3:0]                 iShift,
  input  logic signed [COEFF_W-1:0]  iCoeff,
  input  logic signed [SAMPLE_W-1:0] iResidual,
  input  logic                       iValid,
  output logic signed [SAMPLE_W-1:0] oSample,
  output logic                       oValid
);

  // The accumulator has headroom for MAX_ORDER full-width products and is
  // never narrower than 32 bits.
  localparam int PROD_W = COEFF_W + SAMPLE_W;
  localparam int ACC_W  = (PROD_W + 4 > 32) ? PROD_W + 4 : 32;

  typedef enum logic [1:0] {IDLE, LOAD, WARMUP, DECODE} state_t;

  state_t                     state, state_next;
  logic signed [COEFF_W-1:0]  coeff [MAX_ORDER];
  logic signed [SAMPLE_W-1:0] hist  [MAX_ORDER];
  logic [3:0]                 order;
  logic [3:0]                 shift;
  logic [3:0]                 count;
  logic [3:0]                 m_clamped;
  logic                       capture;
  logic                       store_coeff;
  logic                       emit_warm;
  logic                       emit_decode;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    pred;
  logic signed [SAMPLE_W-1:0] recon;
  logic signed [SAMPLE_W-1:0] sample_out;
  logic                       unused_pred_hi;

  assign m_clamped = (int'(iM) > MAX_ORDER) ? 4'(MAX_ORDER) : iM;

  // Next-state logic. iLoad outside LOAD always restarts the frame and
  // takes priority over a coincident iValid. In LOAD, count is the number
  // of coefficients stored so far. In WARMUP, it is the number of warm-up
  // samples seen.
  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    store_coeff = 1'b0;
    emit_warm   = 1'b0;
    emit_decode = 1'b0;
    if (iEnable) begin
      case (state)
        IDLE:    capture = iLoad;
        LOAD:    store_coeff = iLoad;
        WARMUP:  begin
          capture   = iLoad;
          emit_warm = iValid && !iLoad;
        end
        DECODE:  begin
          capture     = iLoad;
          emit_decode = iValid && !iLoad;
        end
        default: state_next = IDLE;
      endcase

      if (capture) begin
        if (m_clamped == 4'd0)      state_next = DECODE;
        else if (m_clamped == 4'd1) state_next = WARMUP;
        else                        state_next = LOAD;
      end else if (store_coeff && (count == order - 4'd1)) begin
        state_next = WARMUP;
      end else if (emit_warm && (count == order - 4'd1)) begin
        state_next = DECODE;
      end
    end
  end

  // Prediction. Each product is formed at accumulator width, so it is
  // exact. Taps at or beyond the current order are masked, so coefficients
  // left over from an earlier, longer frame cannot leak in.
  always_comb begin
    acc = '0;
    for (int k = 0; k < MAX_ORDER; k++) begin
      if (k < int'(order)) begin
        acc = acc + (ACC_W'(coeff[k]) * ACC_W'(hist[k]));
      end
    end
  end

  assign pred           = acc >>> shift;
  assign recon          = iResidual + pred[SAMPLE_W-1:0];
  assign sample_out     = emit_warm ? iResidual : recon;
  assign unused_pred_hi = ^pred[ACC_W-1:SAMPLE_W];

  // State, coefficient and history registers. hist[0] is the newest sample
  // s[n-1]. The output is written back into the history on the same edge,
  // so back-to-back residuals see it.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state   <= IDLE;
      order   <= '0;
      shift   <= '0;
      count   <= '0;
      oSample <= '0;
      oValid  <= 1'b0;
      for (int k = 0; k < MAX_ORDER; k++) begin
        coeff[k] <= '0;
        hist[k]  <= '0;
      end
    end else if (iEnable) begin
      oValid <= 1'b0;
      state  <= state_next;
      if (capture) begin
        order    <= m_clamped;
        shift    <= iShift;
        coeff[0] <= iCoeff;
        count    <= (m_clamped > 4'd1) ? 4'd1 : 4'd0;
        for (int k = 0; k < MAX_ORDER; k++) begin
          hist[k] <= '0;
        end
      end else if (store_coeff) begin
        for (int k = 0; k < MAX_ORDER; k++) begin
          if (k == int'(count)) begin
            coeff[k] <= iCoeff;
          end
        end
        count <= (state_next == WARMUP) ? 4'd0 : count + 4'd1;
      end else if (emit_warm || emit_decode) begin
        oSample <= sample_out;
        oValid  <= 1'b1;
        hist[0] <= sample_out;
        for (int k = 1; k < MAX_ORDER; k++) begin
          hist[k] <= hist[k-1];
        end
        if (emit_warm) begin
          count <= (state_next == DECODE) ? 4'd0 : count + 4'd1;
        end
      end
    end else begin
      oValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_residual_decoder.sv
// tb_residual_decoder
//   Self-checking bench for residual_decoder. Directed frames cover the
//   worked examples: warm-up, back-to-back decode, floor shift, wrap, reset
//   and reload. A randomized section compares against a reference model
//   built on integer arithmetic and a history queue.
module tb_residual_decoder;

  logic               iClock = 1'b0;
  logic               iReset;
  logic               iEnable;
  logic               iLoad;
  logic [3:0]         iM;
  logic [3:0]         iShift;
  logic signed [11:0] iCoeff;
  logic signed [15:0] iResidual;
  logic               iValid;
  logic signed [15:0] oSample;
  logic               oValid;

  int vectors     = 0;
  int miscompares = 0;

  residual_decoder dut (
    .iClock    (iClock),
    .iReset    (iReset),
    .iEnable   (iEnable),
    .iLoad     (iLoad),
    .iM        (iM),
    .iShift    (iShift),
    .iCoeff    (iCoeff),
    .iResidual (iResidual),
    .iValid    (iValid),
    .oSample   (oSample),
    .oValid    (oValid)
  );

  always #5 iClock = ~iClock;

  // Drive one cycle of inputs, then return 1 time unit after the edge.
  task automatic step(input logic en, input logic ld, input int m, input int sh,
                      input int c, input logic vld, input int r);
    iEnable   = en;
    iLoad     = ld;
    iM        = 4'(m);
    iShift    = 4'(sh);
    iCoeff    = 12'(c);
    iValid    = vld;
    iResidual = 16'(r);
    @(posedge iClock);
    #1;
  endtask

  // Load a frame: capture cycle with c[0], then the remaining coefficients.
  task automatic load_frame(input int m, input int sh, input int c[12]);
    step(1'b1, 1'b1, m, sh, c[0], 1'b0, 0);
    for (int k = 1; k < m; k++) step(1'b1, 1'b1, 0, 0, c[k], 1'b0, 0);
  endtask

  task automatic test_reset();
    iReset = 1'b0; iEnable = 1'b1; iLoad = 1'b0; iValid = 1'b0;
    iM = '0; iShift = '0; iCoeff = '0; iResidual = '0;
    #12;
    vectors++;
    if (oValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_valid: got %b expected 0", oValid);
    end
    vectors++;
    if (oSample !== 16'sd0) begin
      miscompares++;
      $display("[TB] FAIL reset_sample: got %0d expected 0", oSample);
    end
    @(negedge iClock);
    iReset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 0, 0, 0, 1'b1, 100 + i);
      vectors++;
      if (oValid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL idle_ignores_valid: got %b expected 0", oValid);
      end
    end
  endtask

  task automatic test_warmup_order1();
    int c[12] = '{default: 0};
    int ins[4] = '{5, 1, 1, 1};
    int exp_s[4] = '{5, 6, 7, 8};
    c[0] = 1;
    load_frame(1, 0, c);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 0, 0, 0, 1'b1, ins[i]);
      vectors++;
      if (oValid !== 1'b1 || oSample !== 16'(exp_s[i])) begin
        miscompares++;
        $display("[TB] FAIL order1[%0d]: got v=%b s=%0d expected v=1 s=%0d", i, oValid, oSample, exp_s[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c[12] = '{default: 0};
    int ins[4] = '{10, 12, 0, 0};
    int exp_s[4] = '{10, 12, 14, 16};
    c[0] = 2; c[1] = -1;
    load_frame(2, 0, c);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 0, 0, 0, 1'b1, ins[i]);
      vectors++;
      if (oValid !== 1'b1 || oSample !== 16'(exp_s[i])) begin
        miscompares++;
        $display("[TB] FAIL b2b[%0d]: got v=%b s=%0d expected v=1 s=%0d", i, oValid, oSample, exp_s[i]);
      end
    end
  endtask

  task automatic test_floor_shift();
    int c[12] = '{default: 0};
    int ins[5] = '{4, 0, 0, -3, 0};
    int exp_s[5] = '{4, 6, 9, -3, -5};
    c[0] = 3;
    for (int i = 0; i < 5; i++) begin
      if (i == 0 || i == 3) load_frame(1, 1, c);
      step(1'b1, 1'b0, 0, 0, 0, 1'b1, ins[i]);
      vectors++;
      if (oValid !== 1'b1 || oSample !== 16'(exp_s[i])) begin
        miscompares++;
        $display("[TB] FAIL shift[%0d]: got v=%b s=%0d expected v=1 s=%0d", i, oValid, oSample, exp_s[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int c[12] = '{default: 0};
    int ins[2] = '{32767, 1};
    int exp_s[2] = '{32767, -32768};
    c[0] = 1;
    load_frame(1, 0, c);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 0, 0, 0, 1'b1, ins[i]);
      vectors++;
      if (oValid !== 1'b1 || oSample !== 16'(exp_s[i])) begin
        miscompares++;
        $display("[TB] FAIL wrap[%0d]: got v=%b s=%0d expected v=1 s=%0d", i, oValid, oSample, exp_s[i]);
      end
    end
  endtask

  task automatic test_enable_freeze();
    int c[12] = '{default: 0};
    c[0] = 1;
    load_frame(1, 0, c);
    step(1'b1, 1'b0, 0, 0, 0, 1'b1, 10);
    step(1'b0, 1'b0, 0, 0, 0, 1'b1, 5);
    vectors++;
    if (oValid !== 1'b0 || oSample !== 16'sd10) begin
      miscompares++;
      $display("[TB] FAIL enable_hold: got v=%b s=%0d expected v=0 s=10", oValid, oSample);
    end
    step(1'b0, 1'b1, 0, 0, 7, 1'b0, 0);
    step(1'b1, 1'b0, 0, 0, 0, 1'b1, 1);
    vectors++;
    if (oValid !== 1'b1 || oSample !== 16'sd11) begin
      miscompares++;
      $display("[TB] FAIL enable_resume: got v=%b s=%0d expected v=1 s=11", oValid, oSample);
    end
  endtask

  task automatic test_reset_mid_decode();
    int c[12] = '{default: 0};
    c[0] = 1;
    load_frame(1, 0, c);
    step(1'b1, 1'b0, 0, 0, 0, 1'b1, 3);
    step(1'b1, 1'b0, 0, 0, 0, 1'b1, 1);
    iValid = 1'b0;
    iReset = 1'b0;
    #1;
    vectors++;
    if (oValid !== 1'b0 || oSample !== 16'sd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got v=%b s=%0d expected v=0 s=0", oValid, oSample);
    end
    @(negedge iClock);
    iReset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 0, 0, 0, 1'b1, 20 + i);
      vectors++;
      if (oValid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL post_reset_valid[%0d]: got %b expected 0", i, oValid);
      end
    end
  endtask

  task automatic test_reload_coincident();
    int c[12] = '{default: 0};
    c[0] = 1;
    load_frame(1, 0, c);
    step(1'b1, 1'b0, 0, 0, 0, 1'b1, 50);
    step(1'b1, 1'b0, 0, 0, 0, 1'b1, 1);
    step(1'b1, 1'b1, 0, 0, 9, 1'b1, 99);
    vectors++;
    if (oValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reload_drop: got %b expected 0", oValid);
    end
    step(1'b1, 1'b0, 0, 0, 0, 1'b1, 7);
    vectors++;
    if (oValid !== 1'b1 || oSample !== 16'sd7) begin
      miscompares++;
      $display("[TB] FAIL reload_m0: got v=%b s=%0d expected v=1 s=7", oValid, oSample);
    end
  endtask

  // Random frames compared against a queue-based predictor model.
  task automatic test_random();
    int                 c[12];
    int                 m_raw, m_eff, sh, nsamp, res, gap;
    longint             acc, pred;
    logic signed [15:0] e;
    logic signed [15:0] last;
    logic               have_last;
    logic signed [15:0] hist[$];
    for (int f = 0; f < 30; f++) begin
      m_raw = int'($urandom_range(0, 15));
      m_eff = (m_raw > 12) ? 12 : m_raw;
      sh    = int'($urandom_range(0, 15));
      for (int k = 0; k < 12; k++) c[k] = int'($urandom_range(0, 4095)) - 2048;
      hist.delete();
      have_last = 1'b0;
      last      = '0;

      step(1'b1, 1'b1, m_raw, sh, c[0], 1'($urandom_range(0, 1)), 5);
      vectors++;
      if (oValid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rnd_capture f%0d: got %b expected 0", f, oValid);
      end
      for (int k = 1; k < m_eff; k++) begin
        gap = int'($urandom_range(0, 3));
        if (gap == 0) step(1'b0, 1'b1, 0, 0, 1234, 1'b1, 1);
        else if (gap == 1) step(1'b1, 1'b0, 0, 0, 0, 1'b1, 2);
        if (gap < 2) begin
          vectors++;
          if (oValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rnd_load_gap f%0d k%0d: got %b expected 0", f, k, oValid);
          end
        end
        step(1'b1, 1'b1, 0, 0, c[k], 1'($urandom_range(0, 1)), 3);
        vectors++;
        if (oValid !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL rnd_load f%0d k%0d: got %b expected 0", f, k, oValid);
        end
      end

      nsamp = m_eff + int'($urandom_range(3, 10));
      for (int n = 0; n < nsamp; n++) begin
        gap = int'($urandom_range(0, 4));
        if (gap == 0) begin
          step(1'b0, 1'($urandom_range(0, 1)), 0, 0, 0, 1'b1, 77);
          vectors++;
          if (oValid !== 1'b0 || (have_last && oSample !== last)) begin
            miscompares++;
            $display("[TB] FAIL rnd_freeze f%0d n%0d: got v=%b s=%0d expected v=0 s=%0d", f, n, oValid, oSample, last);
          end
        end else if (gap == 1) begin
          step(1'b1, 1'b0, 0, 0, 0, 1'b0, 0);
          vectors++;
          if (oValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rnd_idle f%0d n%0d: got %b expected 0", f, n, oValid);
          end
        end
        res = int'($urandom_range(0, 65535)) - 32768;
        if (n < m_eff) begin
          e = 16'(res);
        end else begin
          acc = 0;
          for (int k = 0; k < m_eff; k++) acc += longint'(c[k]) * longint'(hist[k]);
          pred = acc >>> sh;
          e = 16'(longint'(res) + pred);
        end
        hist.push_front(e);
        step(1'b1, 1'b0, 0, 0, 0, 1'b1, res);
        vectors++;
        if (oValid !== 1'b1 || oSample !== e) begin
          miscompares++;
          $display("[TB] FAIL rnd_sample f%0d n%0d M%0d sh%0d: got v=%b s=%0d expected v=1 s=%0d", f, n, m_eff, sh, oValid, oSample, e);
        end
        last      = e;
        have_last = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_warmup_order1();
    test_back_to_back();
    test_floor_shift();
    test_wrap();
    test_enable_freeze();
    test_reset_mid_decode();
    test_reload_coincident();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
